hazard_stall_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage core. It sits beside the forwarding logic and drives the per-stage register enables and flushes.
- Covers the three hazards forwarding cannot resolve:
  - load-use (one bubble),
  - taken-branch squash (IF/ID and ID/EX flush),
  - multi-cycle data-memory access (full freeze until memory acknowledges, with a timeout to an error state).

---
 rtl/hazard_stall_controller_pkg.sv | 14 +
 rtl/hazard_perf_counter.sv | 16 +
 rtl/hazard_stall_controller.sv | 117 +++++++++++
 tb/tb_hazard_stall_controller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_controller_pkg.sv
// hazard_stall_controller_pkg: opcodes, FSM state encoding and register-address width shared by the hazard controller
`ifndef RSIZE
`define RSIZE 5
`endif

package hazard_stall_controller_pkg;
  localparam logic [3:0] OP_LW = 4'd8;
  localparam logic [3:0] OP_SW = 4'd9;
  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_t;
endpackage

// File: rtl/hazard_perf_counter.sv
// hazard_perf_counter: saturating event counter with synchronous clear
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  // count events, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use bubble, branch squash and data-memory freeze/timeout sequencing for the 5-stage core
// HAZARD_PERF_CNT_EN builds the stall/flush performance counters; otherwise both ports read zero.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [`RSIZE-1:0] ID_RAddr1,
  input  logic [`RSIZE-1:0] ID_RAddr2,
  input  logic              ID_Use1,
  input  logic              ID_Use2,
  input  logic [3:0]        EX_opCode,
  input  logic [`RSIZE-1:0] EX_WAddr,
  input  logic              EX_BrTaken,
  input  logic [3:0]        MEM_opCode,
  input  logic              dmem_ready,
  output logic              PC_en,
  output logic              IFID_en,
  output logic              IDEX_en,
  output logic              EXMEM_en,
  output logic              MEMWB_en,
  output logic              IFID_flush,
  output logic              IDEX_flush,
  output logic              MEMWB_flush,
  output logic              dmem_req,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);
  state_t     state, state_n;
  logic [7:0] wcnt, wcnt_n;
  logic       memop, lu, br_flush;

  assign memop = (MEM_opCode == OP_LW) || (MEM_opCode == OP_SW);
  assign lu    = (EX_opCode == OP_LW) && (EX_WAddr != '0) &&
                 ((ID_Use1 && ID_RAddr1 == EX_WAddr) || (ID_Use2 && ID_RAddr2 == EX_WAddr));

  // state and wait-cycle counter registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_RUN;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end

  // Mealy outputs and next state; a pending memory access outranks branch, which outranks load-use
  always_comb begin
    state_n     = state;
    wcnt_n      = wcnt;
    PC_en       = 1'b1;
    IFID_en     = 1'b1;
    IDEX_en     = 1'b1;
    EXMEM_en    = 1'b1;
    MEMWB_en    = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    MEMWB_flush = 1'b0;
    dmem_req    = 1'b0;
    mem_err     = 1'b0;
    br_flush    = 1'b0;
    case (state)
      S_RUN: begin
        wcnt_n   = '0;
        dmem_req = memop;
        if (memop && !dmem_ready) begin
          {PC_en, IFID_en, IDEX_en, EXMEM_en} = 4'b0000;
          MEMWB_flush = 1'b1;
          state_n     = S_MEM_WAIT;
          wcnt_n      = 8'd1;
        end else if (EX_BrTaken) begin
          IFID_flush = 1'b1;
          IDEX_flush = 1'b1;
          br_flush   = 1'b1;
        end else if (lu) begin
          PC_en      = 1'b0;
          IFID_en    = 1'b0;
          IDEX_flush = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) state_n = S_RUN;
        else begin
          {PC_en, IFID_en, IDEX_en, EXMEM_en} = 4'b0000;
          MEMWB_flush = 1'b1;
          if (wcnt == 8'(MEM_TIMEOUT)) state_n = S_ERR;
          else wcnt_n = wcnt + 8'd1;
        end
      end
      S_ERR: begin
        {PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en} = 5'b00000;
        MEMWB_flush = 1'b1;
        mem_err     = 1'b1;
      end
      default: state_n = S_RUN;
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .clr(1'b0),
    .inc(!PC_en && state != S_ERR), .cnt(stall_cycles)
  );
  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .clr(1'b0),
    .inc(br_flush), .cnt(flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: scoreboard bench with directed scenarios and random traffic against a behavioural model
module tb_hazard_stall_controller;
  localparam int T = 4;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [`RSIZE-1:0] ID_RAddr1 = '0, ID_RAddr2 = '0, EX_WAddr = '0;
  logic        ID_Use1 = 0, ID_Use2 = 0, EX_BrTaken = 0, dmem_ready = 0;
  logic [3:0]  EX_opCode = '0, MEM_opCode = '0;
  logic        PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en;
  logic        IFID_flush, IDEX_flush, MEMWB_flush, dmem_req, mem_err;
  logic [31:0] stall_cycles, flush_count;

  hazard_stall_controller #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_RAddr1(ID_RAddr1), .ID_RAddr2(ID_RAddr2), .ID_Use1(ID_Use1), .ID_Use2(ID_Use2),
    .EX_opCode(EX_opCode), .EX_WAddr(EX_WAddr), .EX_BrTaken(EX_BrTaken),
    .MEM_opCode(MEM_opCode), .dmem_ready(dmem_ready),
    .PC_en(PC_en), .IFID_en(IFID_en), .IDEX_en(IDEX_en), .EXMEM_en(EXMEM_en), .MEMWB_en(MEMWB_en),
    .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .MEMWB_flush(MEMWB_flush),
    .dmem_req(dmem_req), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  o;
    logic        req;
    bit          req_chk;
    logic [31:0] sc;
    logic [31:0] fc;
    int          n;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0, cyc = 0;

  bit     m_wait, m_err;
  int     m_waited;
  longint m_sc, m_fc;

  task automatic step(input bit rst, input logic [`RSIZE-1:0] ra1, input logic [`RSIZE-1:0] ra2,
                      input bit u1, input bit u2, input logic [3:0] exop, input logic [`RSIZE-1:0] wa,
                      input bit br, input logic [3:0] mop, input bit rdy);
    exp_t e;
    bit memop, lu, was_err;
    bit pc, ifid, idex, exmem, memwb, fifid, fidex, fmemwb, err;
    @(posedge clk); #1;
    rst_n = !rst; ID_RAddr1 = ra1; ID_RAddr2 = ra2; ID_Use1 = u1; ID_Use2 = u2;
    EX_opCode = exop; EX_WAddr = wa; EX_BrTaken = br; MEM_opCode = mop; dmem_ready = rdy;
    if (rst) begin m_wait = 0; m_err = 0; m_waited = 0; m_sc = 0; m_fc = 0; end
`ifdef HAZARD_PERF_CNT_EN
    e.sc = 32'(m_sc); e.fc = 32'(m_fc);
`else
    e.sc = 0; e.fc = 0;
`endif
    memop = (mop == 4'd8) || (mop == 4'd9);
    lu = (exop == 4'd8) && (wa != 0) && ((u1 && ra1 == wa) || (u2 && ra2 == wa));
    {pc, ifid, idex, exmem, memwb, fifid, fidex, fmemwb, err} = 9'b11111_0000;
    e.req = 0; e.req_chk = 1;
    was_err = m_err;
    if (m_err) begin
      {pc, ifid, idex, exmem, memwb} = 5'b0; fmemwb = 1; err = 1;
    end else if (m_wait) begin
      e.req = 1;
      if (rdy) m_wait = 0;
      else begin
        {pc, ifid, idex, exmem} = 4'b0; fmemwb = 1;
        if (m_waited == T) m_err = 1; else m_waited++;
      end
    end else if (memop && !rdy) begin
      {pc, ifid, idex, exmem} = 4'b0; fmemwb = 1; e.req = 1;
      if (!rst) begin m_wait = 1; m_waited = 1; end
    end else if (br) begin
      fifid = 1; fidex = 1; e.req_chk = 0;
      if (!rst) m_fc++;
    end else if (lu) begin
      pc = 0; ifid = 0; fidex = 1; e.req_chk = 0;
    end else e.req = memop;
    if (!rst && !was_err && !pc) m_sc++;
    e.o = {pc, ifid, idex, exmem, memwb, fifid, fidex, fmemwb, err};
    e.n = cyc++;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // scoreboard monitor: compare the oldest expectation mid-cycle
  always @(negedge clk) begin
    exp_t e;
    logic [8:0] act;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en, IFID_flush, IDEX_flush, MEMWB_flush, mem_err};
      checks++;
      if (act !== e.o) begin
        errors++;
        $display("FAIL outputs cycle %0d: got %b want %b (pc,ifid,idex,exmem,memwb,fifid,fidex,fmemwb,err)", e.n, act, e.o);
      end
      if (e.req_chk) begin
        checks++;
        if (dmem_req !== e.req) begin
          errors++;
          $display("FAIL dmem_req cycle %0d: got %b want %b", e.n, dmem_req, e.req);
        end
      end
      checks++;
      if (stall_cycles !== e.sc) begin
        errors++;
        $display("FAIL stall_cycles cycle %0d: got %0d want %0d", e.n, stall_cycles, e.sc);
      end
      checks++;
      if (flush_count !== e.fc) begin
        errors++;
        $display("FAIL flush_count cycle %0d: got %0d want %0d", e.n, flush_count, e.fc);
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // load-use, then hazard gone
    step(0, 5, 0, 1, 0, 8, 5, 0, 0, 1);
    idle(1);
    // branch with simultaneous load-use
    step(0, 5, 0, 1, 0, 8, 5, 1, 0, 1);
    idle(1);
    // memory wait: 3 low cycles then ack
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 9, 1);
    idle(1);
    // register zero never stalls
    step(0, 0, 0, 1, 0, 8, 0, 0, 0, 1);
    // ack on the cycle the counter reaches the timeout
    repeat (T) step(0, 0, 0, 0, 0, 0, 0, 0, 8, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 8, 1);
    idle(1);
    // branch during memory stall: flushed after release
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(1);
    // timeout into sticky error, late ack ignored, reset recovers
    repeat (T + 3) step(0, 0, 0, 0, 0, 0, 0, 0, 8, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 8, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // reset abandoning a wait
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] exop, mop;
      exop = ($urandom_range(0, 1) != 0) ? 4'd8 : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: mop = 4'd8;
        1: mop = 4'd9;
        default: mop = 4'($urandom_range(0, 15));
      endcase
      step($urandom_range(0, 49) == 0,
           `RSIZE'($urandom_range(0, 3)), `RSIZE'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), exop,
           `RSIZE'($urandom_range(0, 3)), $urandom_range(0, 5) == 0, mop,
           $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
